// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point constants, divider state encoding and iteration count
package fxp_pkg;
  localparam int FXP_N = 32;
  localparam int FXP_Q = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  function automatic int div_iter(input int n, input int q);
    return n - 1 + q;
  endfunction
  localparam int FXP_ITER = div_iter(FXP_N, FXP_Q);
endpackage

// File: rtl/fxp_div_step.sv
// fxp_div_step: one combinational restoring-division step (shift, trial subtract, restore)
module fxp_div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem_i,
  input  logic         bit_i,
  input  logic [N-2:0] div_i,
  output logic [N-1:0] rem_o,
  output logic         q_o
);
  logic [N:0] sh;
  logic [N:0] diff;
  assign sh    = {rem_i, bit_i};
  assign diff  = sh - {2'b00, div_i};
  assign q_o   = sh >= {2'b00, div_i};
  assign rem_o = q_o ? diff[N-1:0] : sh[N-1:0];
endmodule

// File: rtl/fxp_divider.sv
// fxp_divider: sequential sign-magnitude Qm.Q restoring divider; FXP_DIV_SAT_EN selects saturation on overflow
module fxp_divider
  import fxp_pkg::*;
#(
  parameter int N = FXP_N,
  parameter int Q = FXP_Q
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         ovr
);
  localparam int ITER = div_iter(N, Q);
  localparam int CW   = $clog2(ITER + 1);
  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [ITER-1:0] quo_q, quo_d;
  logic [N-2:0]    dsr_q, dsr_d;
  logic            sign_q, sign_d;
  logic [N-1:0]    out_q, out_d;
  logic            ovr_q, ovr_d;
  logic            hold_q, hold_d;
  logic [N-1:0]    rem_nx;
  logic            q_bit;
  logic [ITER-1:0] quo_nx;
  logic            sgn_in;
  logic            ovr_fin;
  logic [N-2:0]    mag_fin;
  // quo_q doubles as the dividend shifter: dividend bits leave at the top as quotient bits enter at the bottom
  fxp_div_step #(.N(N)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[ITER-1]),
    .div_i (dsr_q),
    .rem_o (rem_nx),
    .q_o   (q_bit)
  );
  assign quo_nx  = {quo_q[ITER-2:0], q_bit};
  assign sgn_in  = a[N-1] ^ b[N-1];
  assign ovr_fin = |quo_nx[ITER-1:N-1];
`ifdef FXP_DIV_SAT_EN
  assign mag_fin = ovr_fin ? {(N-1){1'b1}} : quo_nx[N-2:0];
`else
  assign mag_fin = quo_nx[N-2:0];
`endif
  assign busy = state_q == RUN;
  assign done = (state_q == DONE) && !hold_q;
  assign out  = out_q;
  assign ovr  = ovr_q;
  // state and datapath registers; reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
      ovr_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
      hold_q  <= hold_d;
    end
  end
  // next-state: accept in IDLE, one quotient bit per RUN cycle, one-cycle done pulse
  // divide-by-zero spends one extra DONE cycle (hold) so its done lands two edges after start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    sign_d  = sign_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (start) begin
        sign_d = sgn_in;
        dsr_d  = b[N-2:0];
        if (b[N-2:0] == '0) begin
          out_d   = {sgn_in, {(N-1){1'b1}}};
          ovr_d   = 1'b1;
          hold_d  = 1'b1;
          state_d = DONE;
        end else begin
          rem_d   = '0;
          quo_d   = {a[N-2:0], {Q{1'b0}}};
          cnt_d   = CW'(ITER);
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = {sign_q, mag_fin};
          ovr_d   = ovr_fin;
          state_d = DONE;
        end
      end
      DONE: begin
        hold_d  = 1'b0;
        state_d = hold_q ? DONE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
